// File: rtl/regfile_write_bank_pkg.sv
// Shared constants and types for the integer register file write side.
package rv_regfile_pkg;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  typedef logic [AW-1:0]   reg_addr_t;
  typedef logic [XLEN-1:0] xword_t;

  typedef struct packed {
    logic      en;
    reg_addr_t addr;
    xword_t    data;
  } wr_req_t;

  typedef struct packed {
    logic      en;
    reg_addr_t rd;
  } issue_req_t;
endpackage

// File: rtl/regfile_write_bank_if.sv
// Bundle of WB write, ID issue and flush inputs plus the exported register/scoreboard state.
interface regfile_write_bank_if;
  import rv_regfile_pkg::*;

  logic                 wr_en_i;
  reg_addr_t            wr_addr_i;
  xword_t               wr_data_i;
  logic                 issue_en_i;
  reg_addr_t            issue_rd_i;
  logic                 flush_i;
  logic [NREG*XLEN-1:0] regs_o;
  logic [NREG-1:0]      busy_o;
  logic                 wb_unexp_o;

  modport master (
    output wr_en_i, wr_addr_i, wr_data_i, issue_en_i, issue_rd_i, flush_i,
    input  regs_o, busy_o, wb_unexp_o
  );

  modport slave (
    input  wr_en_i, wr_addr_i, wr_data_i, issue_en_i, issue_rd_i, flush_i,
    output regs_o, busy_o, wb_unexp_o
  );
endinterface

// File: rtl/regfile_write_bank_decoder.sv
// Enabled binary-to-one-hot decoder used for the write and issue select vectors.
module decoder_5to32
  import rv_regfile_pkg::*;
#(
  parameter int DAW   = AW,
  parameter int DNREG = NREG
) (
  input  logic             i_en,
  input  logic [DAW-1:0]   i_addr,
  output logic [DNREG-1:0] o_onehot
);
  always_comb begin
    o_onehot = '0;
    if (i_en) o_onehot[i_addr] = 1'b1;
  end
endmodule

// File: rtl/regfile_write_bank.sv
// 32x32 flop bank with x0 tied to zero, plus the pending-write scoreboard for the hazard unit.
module regfile_write_bank
  import rv_regfile_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_ni,
  regfile_write_bank_if.slave  bus
);
  logic [NREG-1:0]            w_wsel;
  logic [NREG-1:0]            w_isel;
  logic [NREG-1:1][XLEN-1:0]  r_regs;
  logic [NREG-1:1]            r_busy;
  logic                       r_unexp;
  logic                       w_unexp;

  decoder_5to32 #(.DAW(AW), .DNREG(NREG)) u_wr_dec (
    .i_en     (bus.wr_en_i),
    .i_addr   (bus.wr_addr_i),
    .o_onehot (w_wsel)
  );

  decoder_5to32 #(.DAW(AW), .DNREG(NREG)) u_iss_dec (
    .i_en     (bus.issue_en_i),
    .i_addr   (bus.issue_rd_i),
    .o_onehot (w_isel)
  );

  // Bit 0 of both select vectors is dropped: x0 has no storage and never goes busy.
  assign w_unexp = |(w_wsel[NREG-1:1] & ~r_busy);

  for (genvar k = 1; k < NREG; k++) begin : g_reg
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)        r_regs[k] <= '0;
      else if (w_wsel[k]) r_regs[k] <= bus.wr_data_i;
    end

    // Flush beats everything; a younger issue beats a same-cycle writeback clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)           r_busy[k] <= 1'b0;
      else if (bus.flush_i)  r_busy[k] <= 1'b0;
      else if (w_isel[k])    r_busy[k] <= 1'b1;
      else if (w_wsel[k])    r_busy[k] <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_unexp <= 1'b0;
    else         r_unexp <= w_unexp;
  end

  assign bus.regs_o     = {r_regs, {XLEN{1'b0}}};
  assign bus.busy_o     = {r_busy, 1'b0};
  assign bus.wb_unexp_o = r_unexp;
endmodule
